// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared types and default widths for the RAM request controller.
//   state_t     : controller FSM states (IDLE, WR, RD)
//   rsp_entry_t : one response FIFO entry (read data + last-beat flag)
package ram_ctrl_pkg;

  localparam int RC_ADDR_W = 8;
  localparam int RC_DATA_W = 32;
  localparam int RC_LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [RC_DATA_W-1:0] data;
    logic                 last;
  } rsp_entry_t;

endpackage

// File: rtl/ram_req_ctrl_if.sv
// ram_req_ctrl_if
// Command and response channels between a client (master) and the RAM
// request controller (slave).
//   cmd_* : valid/ready command (write or incrementing read burst)
//   rsp_* : valid/ready read response stream with last-beat marker
interface ram_req_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = RC_ADDR_W,
  parameter int DATA_W = RC_DATA_W,
  parameter int LEN_W  = RC_LEN_W
);

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_we_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [LEN_W-1:0]  cmd_len_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_last_o;

  modport master (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i, cmd_wdata_i, rsp_ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o
  );

  modport slave (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i, cmd_wdata_i, rsp_ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o
  );

endinterface

// File: rtl/ram_rsp_fifo.sv
// ram_rsp_fifo
// Synchronous FIFO holding read responses.
//   clk_i      : clock
//   flush_i    : synchronous flush (empties the FIFO)
//   push_i     : write push_data_i
//   pop_i      : drop the head entry
//   pop_data_o : head entry, all zeros while empty
//   full_o / empty_o / count_o : occupancy
// Simultaneous push and pop is accepted when full or empty.
module ram_rsp_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = rsp_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output entry_t           pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign w_pop_ok  = pop_i && !empty_o;
  // When full, the slot being popped is the slot being written.
  assign w_push_ok = push_i && (!full_o || w_pop_ok);

  assign pop_data_o = empty_o ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data_i;
  end

  a_no_underflow: assert property (@(posedge clk_i) disable iff (flush_i)
    !(pop_i && empty_o));

endmodule

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl
// Turns valid/ready commands into single-port RAM cycles: single-beat
// writes and incrementing read bursts of 1..2**LEN_W beats. Read data is
// returned through a response FIFO; beats are only issued when the FIFO is
// guaranteed to have room for them (credit = FIFO count + reads in flight).
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : command / response channels (slave side)
//   ram_cs_o, ram_we_o, ram_addr_o, ram_data_o : registered RAM controls
//   ram_data_i   : RAM read data, valid the cycle after a sampled read
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = RC_ADDR_W,
  parameter int DATA_W    = RC_DATA_W,
  parameter int LEN_W     = RC_LEN_W,
  parameter int RSP_DEPTH = 4   // power of two, >= 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ram_req_ctrl_if.slave     bus,
  output logic              ram_cs_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } entry_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_done, w_done_nxt;   // last beat already issued

  logic              w_accept;
  logic              w_credit;
  logic              w_issue;
  logic              w_issue_we;
  logic              w_issue_last;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [DATA_W-1:0] w_issue_data;

  logic              r_rd_vld_p1, r_last_p1;
  logic              r_rd_vld_p2, r_last_p2;

  logic [CNT_W-1:0]  w_fifo_count;
  logic [CNT_W:0]    w_inflight;
  logic              w_full, w_empty, w_pop;
  entry_t            w_push_data, w_head;

  assign bus.cmd_ready_o = (r_state == IDLE) && !rst_i;
  assign w_accept        = bus.cmd_valid_i && bus.cmd_ready_o;

  // Reads already issued but not yet in the FIFO still need a slot;
  // a pop in this cycle is deliberately not credited.
  assign w_inflight = {1'b0, w_fifo_count}
                    + {{CNT_W{1'b0}}, r_rd_vld_p1}
                    + {{CNT_W{1'b0}}, r_rd_vld_p2};
  assign w_credit   = (w_inflight < (CNT_W+1)'(RSP_DEPTH));

  // The decision made here is what appears on the registered RAM pins in
  // the next cycle, so the first read beat is issued from IDLE on accept.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_cnt_nxt    = r_cnt;
    w_done_nxt   = r_done;
    w_issue      = 1'b0;
    w_issue_we   = 1'b0;
    w_issue_last = 1'b0;
    w_issue_addr = r_addr;
    w_issue_data = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.cmd_we_i) begin
            w_state_nxt  = WR;
            w_issue      = 1'b1;
            w_issue_we   = 1'b1;
            w_issue_addr = bus.cmd_addr_i;
            w_issue_data = bus.cmd_wdata_i;
          end else begin
            w_state_nxt  = RD;
            w_issue_addr = bus.cmd_addr_i;
            w_addr_nxt   = bus.cmd_addr_i;
            w_cnt_nxt    = bus.cmd_len_i;
            w_done_nxt   = 1'b0;
            if (w_credit) begin
              w_issue      = 1'b1;
              w_issue_last = (bus.cmd_len_i == '0);
              w_addr_nxt   = bus.cmd_addr_i + 1'b1;
              w_cnt_nxt    = bus.cmd_len_i - 1'b1;
              w_done_nxt   = (bus.cmd_len_i == '0);
            end
          end
        end
      end
      WR: w_state_nxt = IDLE;
      RD: begin
        if (r_done) begin
          w_state_nxt = IDLE;
        end else if (w_credit) begin
          w_issue      = 1'b1;
          w_issue_last = (r_cnt == '0);
          w_addr_nxt   = r_addr + 1'b1;
          w_cnt_nxt    = r_cnt - 1'b1;
          w_done_nxt   = (r_cnt == '0);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Stage p1: beat on the RAM pins; RAM samples it at the end of this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ram_cs_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_data_o  <= '0;
      r_rd_vld_p1 <= 1'b0;
      r_last_p1   <= 1'b0;
    end else begin
      ram_cs_o    <= w_issue;
      ram_we_o    <= w_issue_we;
      r_rd_vld_p1 <= w_issue && !w_issue_we;
      r_last_p1   <= w_issue_last;
      if (w_issue) begin
        ram_addr_o <= w_issue_addr;
        ram_data_o <= w_issue_data;
      end
    end
  end

  // Stage p2: read data present on ram_data_i, pushed into the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_vld_p2 <= 1'b0;
      r_last_p2   <= 1'b0;
    end else begin
      r_rd_vld_p2 <= r_rd_vld_p1;
      r_last_p2   <= r_last_p1;
    end
  end

  assign w_push_data = '{data: ram_data_i, last: r_last_p2};
  assign w_pop       = bus.rsp_valid_o && bus.rsp_ready_i;

  ram_rsp_fifo #(
    .DEPTH   (RSP_DEPTH),
    .entry_t (entry_t)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .flush_i     (rst_i),
    .push_i      (r_rd_vld_p2),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .pop_data_o  (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_fifo_count)
  );

  assign bus.rsp_valid_o = !w_empty;
  assign bus.rsp_data_o  = w_head.data;
  assign bus.rsp_last_o  = w_head.last;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(r_rd_vld_p2 && w_full && !w_pop));

  a_cs_not_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    !(ram_cs_o && (r_state == IDLE)));

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl
// Directed bench for ram_req_ctrl with a behavioural 256x32 RAM model.
module tb_ram_req_ctrl;

  logic        clk;
  logic        rst;
  logic        ram_init;
  logic        ram_cs;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  ram_req_ctrl_if #(.ADDR_W(8), .DATA_W(32), .LEN_W(4)) bus ();

  ram_req_ctrl #(
    .ADDR_W(8), .DATA_W(32), .LEN_W(4), .RSP_DEPTH(4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .ram_cs_o   (ram_cs),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_data_o (ram_wdata),
    .ram_data_i (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pat(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  // Single-port RAM: one-cycle read latency, preloaded with pat(addr).
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
      ram_rdata <= '0;
    end else if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic we, input logic [7:0] a, input logic [3:0] len,
                      input logic [31:0] d);
    chk("cmd_ready_before_send", 64'(bus.cmd_ready_o), 64'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_addr_i  = a;
    bus.cmd_len_i   = len;
    bus.cmd_wdata_i = d;
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ncs;
    int          k;
    logic [7:0]  a;

    rst             = 1'b1;
    ram_init        = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_len_i   = '0;
    bus.cmd_wdata_i = '0;
    bus.rsp_ready_i = 1'b1;

    // Two reset cycles
    tick();
    ram_init = 1'b0;
    tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    chk("rst_ram_cs",    64'(ram_cs),          64'd0);
    chk("rst_ram_we",    64'(ram_we),          64'd0);
    chk("rst_ram_addr",  64'(ram_addr),        64'd0);
    chk("rst_ram_data",  64'(ram_wdata),       64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_rsp_data",  64'(bus.rsp_data_o),  64'd0);
    chk("rst_rsp_last",  64'(bus.rsp_last_o),  64'd0);
    rst = 1'b0;
    #1;

    // Single write
    send(1'b1, 8'h10, 4'd0, 32'hDEADBEEF);
    chk("wr_cs",        64'(ram_cs),          64'd1);
    chk("wr_we",        64'(ram_we),          64'd1);
    chk("wr_addr",      64'(ram_addr),        64'h10);
    chk("wr_data",      64'(ram_wdata),       64'hDEADBEEF);
    chk("wr_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    tick();
    chk("wr_cs_drop",   64'(ram_cs),          64'd0);
    chk("wr_no_rsp",    64'(bus.rsp_valid_o), 64'd0);

    // Read back the written address, single beat
    send(1'b0, 8'h10, 4'd0, 32'h0);
    chk("rd1_cs",   64'(ram_cs),   64'd1);
    chk("rd1_we",   64'(ram_we),   64'd0);
    chk("rd1_addr", 64'(ram_addr), 64'h10);
    tick();
    chk("rd1_valid_t2", 64'(bus.rsp_valid_o), 64'd0);
    tick();
    chk("rd1_valid_t3", 64'(bus.rsp_valid_o), 64'd1);
    chk("rd1_data",     64'(bus.rsp_data_o),  64'hDEADBEEF);
    chk("rd1_last",     64'(bus.rsp_last_o),  64'd1);
    tick();
    chk("rd1_popped",   64'(bus.rsp_valid_o), 64'd0);

    // Wrapping 4-beat burst from 0xFE
    send(1'b0, 8'hFE, 4'd3, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) begin
        a = 8'hFE + 8'(c - 1);
        chk("b4_cs",   64'(ram_cs),   64'd1);
        chk("b4_addr", 64'(ram_addr), 64'(a));
      end
      if (c == 5) chk("b4_cs_end", 64'(ram_cs), 64'd0);
      if (c >= 3 && c <= 6) begin
        a = 8'hFE + 8'(c - 3);
        chk("b4_valid", 64'(bus.rsp_valid_o), 64'd1);
        chk("b4_data",  64'(bus.rsp_data_o),  64'(pat(a)));
        chk("b4_last",  64'(bus.rsp_last_o),  64'(c == 6));
      end
      tick();
    end

    // 16-beat burst with response channel stalled
    bus.rsp_ready_i = 1'b0;
    send(1'b0, 8'h20, 4'd15, 32'h0);
    ncs = ram_cs ? 1 : 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (ram_cs) ncs++;
    end
    chk("stall_beats",      64'(ncs),             64'd4);
    chk("stall_cs_low",     64'(ram_cs),          64'd0);
    chk("stall_rsp_valid",  64'(bus.rsp_valid_o), 64'd1);
    chk("stall_head_data",  64'(bus.rsp_data_o),  64'(pat(8'h20)));
    bus.rsp_ready_i = 1'b1;
    k = 0;
    for (int i = 0; i < 60 && k < 16; i++) begin
      if (bus.rsp_valid_o) begin
        a = 8'h20 + 8'(k);
        chk("b16_data", 64'(bus.rsp_data_o), 64'(pat(a)));
        chk("b16_last", 64'(bus.rsp_last_o), 64'(k == 15));
        k++;
      end
      tick();
      if (ram_cs) ncs++;
    end
    chk("b16_rsp_count", 64'(k),   64'd16);
    chk("b16_cs_count",  64'(ncs), 64'd16);
    tick();
    chk("b16_drained",   64'(bus.rsp_valid_o), 64'd0);

    // Reset in the middle of a burst
    send(1'b0, 8'h40, 4'd15, 32'h0);
    ncs = ram_cs ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ram_cs) ncs++;
    end
    chk("mid_beats", 64'(ncs), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_cs",        64'(ram_cs),          64'd0);
    chk("mid_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rsp_valid_o) k++;
      if (ram_cs) k++;
    end
    chk("mid_discarded", 64'(k), 64'd0);

    // Normal operation after the reset
    send(1'b1, 8'h41, 4'd0, 32'h12345678);
    tick();
    send(1'b0, 8'h40, 4'd1, 32'h0);
    chk("post_addr", 64'(ram_addr), 64'h40);
    tick();
    tick();
    chk("post_valid0", 64'(bus.rsp_valid_o), 64'd1);
    chk("post_data0",  64'(bus.rsp_data_o),  64'(pat(8'h40)));
    chk("post_last0",  64'(bus.rsp_last_o),  64'd0);
    tick();
    chk("post_data1",  64'(bus.rsp_data_o),  64'h12345678);
    chk("post_last1",  64'(bus.rsp_last_o),  64'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
Request-side controller placed directly upstream of the single-port 256x32 RAM; it drives the RAM chip-select, write-enable, address and write-data and consumes its read data. It converts valid/ready command transactions into RAM cycles: single-beat writes and incrementing read bursts of 1-16 beats. Read data returns on a valid/ready response channel through a small response FIFO. It tracks RAM read latency and applies credit-based backpressure so that no read data is ever lost.

Parameters:
ADDR_W, 8, RAM address width; the address wraps modulo 2**ADDR_W
DATA_W, 32, RAM data width
LEN_W, 4, burst length field width; encodes beats-1, so 1..16 beats
RSP_DEPTH, 4, response FIFO depth in entries; must be a power of two and at least 3

Ports:
clk_i  input  1  clock; all logic on posedge
rst_i  input  1  synchronous reset, active-high
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command ready
cmd_we_i  input  1  1 = write, 0 = read
cmd_addr_i  input  ADDR_W  start address
cmd_len_i  input  LEN_W  read beats-1; ignored for writes
cmd_wdata_i  input  DATA_W  write data
rsp_valid_o  output  1  read response valid
rsp_ready_i  input  1  read response ready
rsp_data_o  output  DATA_W  read data
rsp_last_o  output  1  marks the final beat of a burst
ram_cs_o  output  1  to RAM chip select
ram_we_o  output  1  to RAM write enable
ram_addr_o  output  ADDR_W  to RAM address
ram_data_o  output  DATA_W  to RAM write data
ram_data_i  input  DATA_W  from RAM read data; valid the cycle after a sampled read

Behaviour:
- Reset (rst_i=1 at posedge):
  - state=IDLE; cmd_ready_o=0 during the reset cycle, then 1.
  - ram_cs_o=0, ram_we_o=0, ram_addr_o=0, ram_data_o=0.
  - FIFO flushed; rsp_valid_o=0, rsp_data_o=0, rsp_last_o=0.
  - Pending-read pipeline cleared.
- All ram_* outputs are registered. ram_cs_o is high for exactly one cycle per beat.
- FSM states: IDLE, WR, RD.
  - cmd_ready_o = (state==IDLE) and not in reset.
  - IDLE: on cmd_valid_i&cmd_ready_o, latch the command.
    - Write: go to WR.
    - Read: go to RD with beat_cnt=cmd_len_i and addr=cmd_addr_i.
  - WR: drive one cycle of ram_cs_o=1, ram_we_o=1 with the latched addr/data, then go to IDLE. Next command can be accepted 2 cycles after the previous one.
  - RD: each cycle with credit available, drive ram_cs_o=1, ram_we_o=0, ram_addr_o=addr.
    - Then addr<=addr+1 (wraps 0xFF->0x00) and beat_cnt decrements.
    - After the beat where beat_cnt==0 has issued, go to IDLE.
    - Cycles without credit drive ram_cs_o=0 and hold the counters.
- Credit rule: issue a read beat only if fifo_count + pending < RSP_DEPTH.
  - pending is the number of issued reads not yet captured (0..2).
  - Pops in the same cycle are not counted; this is conservative.
- Read pipeline and latency:
  - Command accepted at cycle T, ram_cs_o=1 at T+1.
  - RAM data is on ram_data_i at T+2 and pushed into the FIFO at the end of T+2.
  - rsp_valid_o=1 at T+3.
  - Each pipeline entry carries a last flag, set for the beat issued with beat_cnt==0.
- Throughput: back-to-back read beats, one per cycle, while rsp_ready_i stays high.
- Response channel:
  - rsp_valid_o = FIFO not empty; the head entry drives rsp_data_o/rsp_last_o.
  - Pop on rsp_valid_o&rsp_ready_i.
  - Data is stable while valid&&!ready.
  - A simultaneous push and pop is legal, including when full (the credit rule prevents overflow) and when empty (valid rises next cycle).
- Writes never produce a response.
- A write issued in cycle N followed by a read of the same address is ordered by the single RAM port; the read returns the new data.
- Reset mid-burst: the burst is abandoned and in-flight read data is discarded. The RAM's own reset is independent.
- Assertions:
  - no FIFO push when full;
  - no FIFO pop when empty;
  - ram_cs_o never high in IDLE.

Decomposition:
- Package ram_ctrl_pkg holds:
  - state enum {IDLE, WR, RD};
  - ADDR_W/DATA_W/LEN_W default constants;
  - response entry struct {data, last}.
- One sub-module: ram_rsp_fifo, a synchronous FIFO with push/pop, full/empty, count, and a flush on reset.

Test Plan:
- Assert rst_i for 2 cycles -> all outputs 0; cmd_ready_o=1 in the first cycle after reset drops.
- Write addr=0x10, data=0xDEADBEEF accepted at T -> at T+1 ram_cs_o=1, ram_we_o=1, ram_addr_o=0x10, ram_data_o=0xDEADBEEF; ram_cs_o=0 at T+2; no response.
- After that write, read addr=0x10, len=0 -> rsp_valid_o=1 at T+3 with rsp_data_o=0xDEADBEEF, rsp_last_o=1.
- Read addr=0xFE, len=3 with rsp_ready_i=1 -> ram_addr_o=FE,FF,00,01 on 4 consecutive cycles; 4 responses back-to-back; last set only on the 4th.
- Read len=15 with rsp_ready_i=0 -> exactly RSP_DEPTH (4) beats issued, then ram_cs_o stays 0. Release ready -> all 16 beats return in order, none lost or duplicated.
- Assert rst_i for 1 cycle mid-burst (after 5 beats) -> the next cycle ram_cs_o=0 and rsp_valid_o=0; a new command is accepted normally afterwards.
